// File: rtl/life_cmd_sequencer.sv
// life_cmd_sequencer: turns SEED/ADVANCE button commands into seed/step handshakes with the Life engine.
// Optional build macro LIFE_SEQ_ABORT_EN: a SEED arriving during an ADVANCE run cuts the run short.
module life_cmd_sequencer #(
  parameter logic [23:0] STEP_GAP_CYCLES = 24'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cmd_i,
  input  logic [31:0] cmd_arg0_i,
  input  logic        cmd_valid_i,
  output logic        seed_start_o,
  output logic [31:0] seed_value_o,
  input  logic        seed_done_i,
  output logic        step_start_o,
  input  logic        step_done_i,
  output logic        busy_o,
  output logic        cmd_dropped_o,
  output logic [31:0] gen_count_o
);

  localparam logic [2:0] CMD_SEED_C    = 3'd1;
  localparam logic [2:0] CMD_ADVANCE_C = 3'd2;
`ifdef LIFE_SEQ_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEED_WAIT = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_STEP_GAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [2:0]  pend_cmd_q, pend_cmd_d;
  logic [31:0] pend_arg_q, pend_arg_d;
  logic [31:0] seed_value_q, seed_value_d;
  logic [31:0] gen_count_q, gen_count_d;
  logic [31:0] remaining_q, remaining_d;
  logic [23:0] gap_cnt_q, gap_cnt_d;
  logic        seed_start_q, seed_start_d;
  logic        step_start_q, step_start_d;
  logic        dropped_q, dropped_d;
  logic        busy_q, busy_d;

  logic        cmd_known_s;
  logic        in_run_s;
  logic        abort_s;
  logic        launch_s;
  logic [2:0]  launch_cmd_s;
  logic [31:0] launch_arg_s;

  assign cmd_known_s = cmd_valid_i & ((cmd_i == CMD_SEED_C) | (cmd_i == CMD_ADVANCE_C));
  assign in_run_s    = (state_q == ST_STEP_WAIT) | (state_q == ST_STEP_GAP);
  assign abort_s     = ABORT_EN & cmd_known_s & (cmd_i == CMD_SEED_C) & in_run_s;

  // Next-state, pending-slot and start-pulse logic.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    pend_arg_d   = pend_arg_q;
    seed_value_d = seed_value_q;
    gen_count_d  = gen_count_q;
    remaining_d  = remaining_q;
    gap_cnt_d    = gap_cnt_q;
    seed_start_d = 1'b0;
    step_start_d = 1'b0;
    dropped_d    = 1'b0;
    launch_s     = 1'b0;
    launch_cmd_s = cmd_i;
    launch_arg_s = cmd_arg0_i;

    case (state_q)
      ST_IDLE: begin
        // A parked command always has priority over a fresh one.
        if (pend_valid_q) begin
          launch_s     = 1'b1;
          launch_cmd_s = pend_cmd_q;
          launch_arg_s = pend_arg_q;
          pend_valid_d = 1'b0;
        end else begin
          launch_s = cmd_known_s;
        end
      end
      ST_SEED_WAIT: begin
        if (seed_done_i) begin
          gen_count_d = 32'd0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SEED_WAIT;
        end
      end
      ST_STEP_WAIT: begin
        if (step_done_i) begin
          gen_count_d = gen_count_q + 32'd1;
          if (abort_s || (remaining_q <= 32'd1)) begin
            remaining_d = 32'd0;
            state_d     = ST_IDLE;
          end else begin
            remaining_d = remaining_q - 32'd1;
            if (STEP_GAP_CYCLES == 24'd0) begin
              step_start_d = 1'b1;
            end else begin
              state_d   = ST_STEP_GAP;
              gap_cnt_d = STEP_GAP_CYCLES - 24'd1;
            end
          end
        end else if (abort_s) begin
          remaining_d = 32'd0;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_STEP_GAP: begin
        if (abort_s) begin
          remaining_d = 32'd0;
          state_d     = ST_IDLE;
        end else if (gap_cnt_q == 24'd0) begin
          step_start_d = 1'b1;
          state_d      = ST_STEP_WAIT;
        end else begin
          gap_cnt_d = gap_cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Commands not launched directly go to the single pending slot or are dropped.
    if (cmd_known_s && !((state_q == ST_IDLE) && !pend_valid_q)) begin
      if (abort_s || !pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_cmd_d   = cmd_i;
        pend_arg_d   = cmd_arg0_i;
      end else begin
        dropped_d = 1'b1;
      end
    end else begin
      dropped_d = 1'b0;
    end

    if (launch_s) begin
      if (launch_cmd_s == CMD_SEED_C) begin
        seed_value_d = launch_arg_s;
        seed_start_d = 1'b1;
        state_d      = ST_SEED_WAIT;
      end else if (launch_arg_s != 32'd0) begin
        remaining_d  = launch_arg_s;
        step_start_d = 1'b1;
        state_d      = ST_STEP_WAIT;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      launch_cmd_s = launch_cmd_s;
    end

    busy_d = (state_d != ST_IDLE) | pend_valid_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= 3'd0;
      pend_arg_q   <= 32'd0;
      seed_value_q <= 32'd0;
      gen_count_q  <= 32'd0;
      remaining_q  <= 32'd0;
      gap_cnt_q    <= 24'd0;
      seed_start_q <= 1'b0;
      step_start_q <= 1'b0;
      dropped_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      pend_arg_q   <= pend_arg_d;
      seed_value_q <= seed_value_d;
      gen_count_q  <= gen_count_d;
      remaining_q  <= remaining_d;
      gap_cnt_q    <= gap_cnt_d;
      seed_start_q <= seed_start_d;
      step_start_q <= step_start_d;
      dropped_q    <= dropped_d;
      busy_q       <= busy_d;
    end
  end

  assign seed_start_o  = seed_start_q;
  assign seed_value_o  = seed_value_q;
  assign step_start_o  = step_start_q;
  assign busy_o        = busy_q;
  assign cmd_dropped_o = dropped_q;
  assign gen_count_o   = gen_count_q;

endmodule
